// File: rtl/adpcm_mul_share_arb.sv
// Round-robin sharing of one pipelined signed-by-unsigned multiplier among NUM_REQ requesters.
// Optional per-requester grant and stall counters: define ADPCM_MUL_ARB_STATS_EN.
module adpcm_mul_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2,
  parameter int A_WIDTH     = 16,
  parameter int B_WIDTH     = 15,
  parameter int P_WIDTH     = 31
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       busy
`ifdef ADPCM_MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      grant_cnt,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]               rr_ptr;
  logic [PW-1:0]               win_idx;
  logic [PW-1:0]               nxt_ptr;
  logic                        found;
  int unsigned                 k;
  logic signed [A_WIDTH-1:0]   sel_a;
  logic [B_WIDTH-1:0]          sel_b;
  logic signed [P_WIDTH-1:0]   prod;

  logic [MUL_LATENCY-1:0]      stg_v;
  logic [P_WIDTH-1:0]          stg_p  [MUL_LATENCY];
  logic [NUM_REQ-1:0]          stg_id [MUL_LATENCY];
  logic [MUL_LATENCY-1:0]      d_v;
  logic [P_WIDTH-1:0]          d_p    [MUL_LATENCY];
  logic [NUM_REQ-1:0]          d_id   [MUL_LATENCY];

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[k[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = k[PW-1:0];
      end
    end
    if (ap_rst) found = 1'b0;
    req_ready = '0;
    if (found) req_ready[win_idx] = 1'b1;
    nxt_ptr = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
  end

  // Product fits exactly in A_WIDTH+B_WIDTH signed bits once b is zero-extended.
  always_comb begin
    sel_a = req_a[win_idx*A_WIDTH +: A_WIDTH];
    sel_b = req_b[win_idx*B_WIDTH +: B_WIDTH];
    prod  = sel_a * $signed({1'b0, sel_b});
  end

  always_comb begin
    d_v    = stg_v << 1;
    d_v[0] = found;
    d_p[0] = prod;
    d_id[0] = req_ready;
    for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
      d_p[s]  = stg_p[s-1];
      d_id[s] = stg_id[s-1];
    end
    // Final stage doubles as the output register: zero it when empty.
    if (!d_v[MUL_LATENCY-1]) begin
      d_p[MUL_LATENCY-1]  = '0;
      d_id[MUL_LATENCY-1] = '0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr <= '0;
      stg_v  <= '0;
      for (int unsigned s = 0; s < MUL_LATENCY; s++) begin
        stg_p[s]  <= '0;
        stg_id[s] <= '0;
      end
    end else begin
      if (found) rr_ptr <= nxt_ptr;
      stg_v <= d_v;
      for (int unsigned s = 0; s < MUL_LATENCY; s++) begin
        stg_p[s]  <= d_p[s];
        stg_id[s] <= d_id[s];
      end
    end
  end

  assign rsp_valid = stg_id[MUL_LATENCY-1];
  assign rsp_p     = stg_p[MUL_LATENCY-1];
  assign busy      = |stg_v;

`ifdef ADPCM_MUL_ARB_STATS_EN
  logic [15:0] gcnt [NUM_REQ];
  logic [15:0] scnt;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      scnt <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) gcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++)
        if (req_ready[i] && gcnt[i] != '1) gcnt[i] <= gcnt[i] + 16'd1;
      if ((req_valid & ~req_ready) != '0 && scnt != '1) scnt <= scnt + 16'd1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = gcnt[i];
  end
  assign stall_cnt = scnt;
`endif

endmodule

// File: tb/tb_adpcm_mul_share_arb.sv
// Self-checking bench: directed vector table plus randomized traffic against a queue-based model.
module tb_adpcm_mul_share_arb;
  localparam int N = 4, L = 2, AW = 16, BW = 15, PW = 31;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [PW-1:0]   rsp_p;
  logic            busy;
`ifdef ADPCM_MUL_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  adpcm_mul_share_arb #(
    .NUM_REQ(N), .MUL_LATENCY(L), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
`ifdef ADPCM_MUL_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: responses scheduled by due cycle, pointer as plain integer.
  typedef struct { int due; logic [N-1:0] id; logic [PW-1:0] p; } rsp_t;
  rsp_t q[$];
  int m_ptr = 0, cyc = 0, m_stall = 0;
  int m_gcnt[N];
  logic [N-1:0]  s_ready, s_rv;
  logic [PW-1:0] s_rp;
  logic          s_busy;

  task automatic do_cycle(input logic rst, input logic [N-1:0] v,
                          input logic [N*AW-1:0] a, input logic [N*BW-1:0] b);
    logic [N-1:0] e_ready, e_rv;
    logic [PW-1:0] e_rp;
    logic e_busy;
    int w, k;
    longint prod;
    logic signed [AW-1:0] aa;
    logic [BW-1:0] bb;
    rsp_t r;
    @(negedge ap_clk);
    ap_rst = rst; req_valid = v; req_a = a; req_b = b;
    #1;
    w = -1;
    if (!rst)
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (w < 0 && v[k]) w = k;
      end
    e_ready = '0;
    if (w >= 0) e_ready[w] = 1'b1;
    e_busy = (q.size() != 0);
    e_rv = '0; e_rp = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      e_rv = q[0].id; e_rp = q[0].p;
      void'(q.pop_front());
    end
    s_ready = req_ready; s_rv = rsp_valid; s_rp = rsp_p; s_busy = busy;
    chk($sformatf("model ready c%0d", cyc), s_ready, e_ready);
    chk($sformatf("model rsp_valid c%0d", cyc), s_rv, e_rv);
    chk($sformatf("model rsp_p c%0d", cyc), s_rp, e_rp);
    chk($sformatf("model busy c%0d", cyc), s_busy, e_busy);
`ifdef ADPCM_MUL_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("grant_cnt[%0d] c%0d", i, cyc), grant_cnt[i*16 +: 16], m_gcnt[i]);
    chk($sformatf("stall_cnt c%0d", cyc), stall_cnt, m_stall);
`endif
    if (rst) begin
      q.delete(); m_ptr = 0; m_stall = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    end else begin
      if (w >= 0) begin
        aa = a[w*AW +: AW]; bb = b[w*BW +: BW];
        prod = longint'(aa) * longint'(bb);
        r.due = cyc + L; r.id = e_ready; r.p = prod[PW-1:0];
        q.push_back(r);
        m_ptr = (w + 1) % N;
        if (m_gcnt[w] < 65535) m_gcnt[w]++;
      end
      if ((v & ~e_ready) != '0 && m_stall < 65535) m_stall++;
    end
    cyc++;
  endtask

  typedef struct {
    logic rst; logic [N-1:0] v; logic [N*AW-1:0] a; logic [N*BW-1:0] b;
    logic [N-1:0] ready, rv; logic [PW-1:0] rp; logic busy;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rst, input logic [3:0] v,
                              input int a0, a1, a2, a3, input int b0, b1, b2, b3,
                              input logic [3:0] ready, rv, input logic [30:0] rp,
                              input logic bsy);
    vec_t t;
    t.rst = rst; t.v = v;
    t.a = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    t.b = {15'(b3), 15'(b2), 15'(b1), 15'(b0)};
    t.ready = ready; t.rv = rv; t.rp = rp; t.busy = bsy;
    tbl.push_back(t);
  endfunction

  function automatic logic [N*AW-1:0] rnd_a();
    logic [N*AW-1:0] x;
    for (int i = 0; i < N; i++)
      case ($urandom_range(0, 3))
        0: x[i*AW +: AW] = 16'h8000;
        1: x[i*AW +: AW] = 16'h7FFF;
        default: x[i*AW +: AW] = 16'($urandom);
      endcase
    return x;
  endfunction

  function automatic logic [N*BW-1:0] rnd_b();
    logic [N*BW-1:0] x;
    for (int i = 0; i < N; i++)
      case ($urandom_range(0, 3))
        0: x[i*BW +: BW] = 15'h0000;
        1: x[i*BW +: BW] = 15'h7FFF;
        default: x[i*BW +: BW] = 15'($urandom);
      endcase
    return x;
  endfunction

  logic [30:0] rr_prod [4];
  logic [N-1:0]    pend;
  logic [N*AW-1:0] ra, na;
  logic [N*BW-1:0] rb, nb;

  initial begin
    rr_prod[0] = 31'h64; rr_prod[1] = 31'h7FFFFE70;
    rr_prod[2] = 31'h384; rr_prod[3] = 31'h7FFFF9C0;
    // single request, then latency-2 result and idle
    add(0, 4'b0001, -3, 0, 0, 0, 5, 0, 0, 0, 4'b0001, 4'b0000, 31'h0, 1'b0);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 31'h0, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0001, 31'h7FFFFFF1, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 31'h0, 1'b0);
    // operand extremes and zero b
    add(0, 4'b0001, -32768, 0, 0, 0, 32767, 0, 0, 0, 4'b0001, 4'b0000, 31'h0, 1'b0);
    add(0, 4'b0010, 0, 32767, 0, 0, 0, 32767, 0, 0, 4'b0010, 4'b0000, 31'h0, 1'b1);
    add(0, 4'b0100, 0, 0, 1234, 0, 0, 0, 0, 0, 4'b0100, 4'b0001, 31'h40008000, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 31'h3FFF0001, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0100, 31'h0, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 31'h0, 1'b0);
    // reset, then all four requesting continuously
    add(1, 4'b1111, 1, -2, 3, -4, 100, 200, 300, 400, 4'b0000, 4'b0000, 31'h0, 1'b0);
    for (int r = 0; r < 8; r++)
      add(0, 4'b1111, 1, -2, 3, -4, 100, 200, 300, 400, 4'(1 << (r % 4)),
          (r >= 2) ? 4'(1 << ((r - 2) % 4)) : 4'b0000,
          (r >= 2) ? rr_prod[(r - 2) % 4] : 31'h0, r > 0);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0100, 31'h384, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1000, 31'h7FFFF9C0, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 31'h0, 1'b0);
    // pointer wrap with requesters 1 and 3
    add(0, 4'b0010, 0, 5, 0, 0, 0, 1, 0, 0, 4'b0010, 4'b0000, 31'h0, 1'b0);
    add(0, 4'b1010, 0, 5, 0, 7, 0, 1, 0, 2, 4'b1000, 4'b0000, 31'h0, 1'b1);
    add(0, 4'b1010, 0, 5, 0, 7, 0, 1, 0, 2, 4'b0010, 4'b0010, 31'h5, 1'b1);
    add(0, 4'b1010, 0, 5, 0, 7, 0, 1, 0, 2, 4'b1000, 4'b1000, 31'hE, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 31'h5, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1000, 31'hE, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 31'h0, 1'b0);
    // reset while a product is in flight
    add(0, 4'b0100, 0, 0, 9, 0, 0, 0, 9, 0, 4'b0100, 4'b0000, 31'h0, 1'b0);
    add(1, 4'b0110, 0, 5, 9, 0, 0, 1, 9, 0, 4'b0000, 4'b0000, 31'h0, 1'b1);
    add(1, 4'b0110, 0, 5, 9, 0, 0, 1, 9, 0, 4'b0000, 4'b0000, 31'h0, 1'b0);
    add(0, 4'b0110, 0, 5, 9, 0, 0, 1, 9, 0, 4'b0010, 4'b0000, 31'h0, 1'b0);
    add(0, 4'b0100, 0, 5, 9, 0, 0, 1, 9, 0, 4'b0100, 4'b0000, 31'h0, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 31'h5, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0100, 31'h51, 1'b1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 31'h0, 1'b0);

    ap_rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge ap_clk);

    foreach (tbl[i]) begin
      do_cycle(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d ready", i), s_ready, tbl[i].ready);
      chk($sformatf("tbl%0d rsp_valid", i), s_rv, tbl[i].rv);
      chk($sformatf("tbl%0d rsp_p", i), s_rp, tbl[i].rp);
      chk($sformatf("tbl%0d busy", i), s_busy, tbl[i].busy);
    end

    // Random traffic: each requester holds valid and operands until granted.
    pend = '0; ra = '0; rb = '0;
    for (int c = 0; c < 800; c++) begin
      na = rnd_a(); nb = rnd_b();
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          ra[i*AW +: AW] = na[i*AW +: AW];
          rb[i*BW +: BW] = nb[i*BW +: BW];
        end
      do_cycle($urandom_range(0, 79) == 0, pend, ra, rb);
      pend = pend & ~s_ready;
    end
    repeat (L + 1) do_cycle(1'b0, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
